// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
// Requester-side handshake bundle for the RAM-backed FIFO controller.
//   master : requester (drives push, push_data, pop)
//   slave  : controller (drives acks, pop_valid/pop_data, status, error flags)
// Signals:
//   push/push_data/pop         write and read requests
//   push_ack/pop_ack           combinational accept strobes
//   pop_valid/pop_data         read return, one cycle after pop_ack
//   full/empty/count           occupancy status from the registered count
//   ovf/udf                    sticky overflow / underflow flags
interface ram_fifo_ctrl_if #(
  parameter int DW = 32
);
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic          push_ack;
  logic          pop_ack;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          full;
  logic          empty;
  logic [5:0]    count;
  logic          ovf;
  logic          udf;

  modport master (
    output push, push_data, pop,
    input  push_ack, pop_ack, pop_valid, pop_data, full, empty, count, ovf, udf
  );

  modport slave (
    input  push, push_data, pop,
    output push_ack, pop_ack, pop_valid, pop_data, full, empty, count, ovf, udf
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// 32-entry FIFO controller using an external 32x32 single-port RAM with a
// registered read port as storage. Turns push/pop requests into RAM
// cen/wen/addr/din cycles, tracks pointers and occupancy, returns popped
// words one cycle after the pop is accepted, and flags overflow/underflow.
// Ports:
//   clk       system clock, all state updates on posedge
//   reset     synchronous active-high reset
//   fif       requester handshake (ram_fifo_ctrl_if.slave)
//   ram_cen   RAM chip enable      (combinational)
//   ram_wen   RAM write enable     (combinational)
//   ram_addr  RAM address          (combinational)
//   ram_din   RAM write data       (combinational)
//   ram_dout  RAM registered read data
// Build option:
//   RAM_FIFO_HOLD_EN  when defined, a hold register keeps the last popped
//                     word on pop_data outside pop_valid cycles.
module ram_fifo_ctrl #(
  parameter int DEPTH = 32,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  ram_fifo_ctrl_if.slave    fif,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [4:0]        ram_addr,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout
);

  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  logic [4:0]    wr_ptr_r;
  logic [4:0]    rd_ptr_r;
  logic [5:0]    count_r;
  logic          pop_valid_r;
  logic          ovf_r;
  logic          udf_r;
  logic          full_s;
  logic          empty_s;
  logic          pop_ack_s;
  logic          push_ack_s;

  // Status comes from the registered count only; pointers may be equal in
  // both the full and the empty case.
  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == 6'd0);

  // One RAM port: a pop wins, a simultaneous push must be retried.
  assign pop_ack_s  = fif.pop & ~empty_s;
  assign push_ack_s = fif.push & ~full_s & ~pop_ack_s;

  // RAM command decode; bus is parked at zero when no access is made.
  always_comb begin
    ram_cen  = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = 5'd0;
    ram_din  = '0;
    if (pop_ack_s) begin
      ram_cen  = 1'b1;
      ram_addr = rd_ptr_r;
    end else if (push_ack_s) begin
      ram_cen  = 1'b1;
      ram_wen  = 1'b1;
      ram_addr = wr_ptr_r;
      ram_din  = fif.push_data;
    end else begin
      ram_cen  = 1'b0;
    end
  end

  // Pointer, occupancy, read-valid and sticky error flag state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= 5'd0;
      rd_ptr_r    <= 5'd0;
      count_r     <= 6'd0;
      pop_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
    end else begin
      // pop_ack and push_ack are mutually exclusive by construction.
      if (pop_ack_s) begin
        rd_ptr_r <= rd_ptr_r + 5'd1;
        count_r  <= count_r - 6'd1;
      end else if (push_ack_s) begin
        wr_ptr_r <= wr_ptr_r + 5'd1;
        count_r  <= count_r + 6'd1;
      end
      pop_valid_r <= pop_ack_s;
      ovf_r       <= ovf_r | (fif.push & full_s);
      udf_r       <= udf_r | (fif.pop & empty_s);
    end
  end

`ifdef RAM_FIFO_HOLD_EN
  logic [DW-1:0] hold_r;

  // Capture each returned word so it stays visible until the next pop completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r <= '0;
    end else if (pop_valid_r) begin
      hold_r <= ram_dout;
    end
  end

  assign fif.pop_data = pop_valid_r ? ram_dout : hold_r;
`else
  assign fif.pop_data = ram_dout;
`endif

  assign fif.push_ack  = push_ack_s;
  assign fif.pop_ack   = pop_ack_s;
  assign fif.pop_valid = pop_valid_r;
  assign fif.full      = full_s;
  assign fif.empty     = empty_s;
  assign fif.count     = count_r;
  assign fif.ovf       = ovf_r;
  assign fif.udf       = udf_r;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
// Self-checking bench for ram_fifo_ctrl: directed scenarios followed by
// randomized push/pop/reset traffic, all compared against a queue-based
// reference model. A behavioural 32x32 RAM with registered read is attached.
module tb_ram_fifo_ctrl;

  logic        clk;
  logic        reset;
  logic        ram_cen;
  logic        ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [31:0] mem [32];

  int checks;
  int errors;

  ram_fifo_ctrl_if #(.DW(32)) fif ();

  ram_fifo_ctrl #(.DEPTH(32), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .fif      (fif.slave),
    .ram_cen  (ram_cen),
    .ram_wen  (ram_wen),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, registered read; drives 0 on write and idle cycles.
  always @(posedge clk) begin
    if (ram_cen && ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= (ram_cen && !ram_wen) ? mem[ram_addr] : 32'h0;
  end

  // Reference model state
  logic [31:0] q_m [$];
  int unsigned n_push_m;
  int unsigned n_pop_m;
  bit          ovf_m;
  bit          udf_m;
  bit          valid_m;
  logic [31:0] data_m;
  logic [31:0] hold_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    n_push_m = 0;
    n_pop_m  = 0;
    ovf_m    = 1'b0;
    udf_m    = 1'b0;
    valid_m  = 1'b0;
    data_m   = 32'h0;
    hold_m   = 32'h0;
  endtask

  // One clock cycle: drive inputs, check settled outputs, clock, update model.
  task automatic cyc(input bit p, input bit q, input logic [31:0] d, input bit r);
    bit exp_pop_ack;
    bit exp_push_ack;
    bit m_full;
    bit m_empty;
    fif.push      = p;
    fif.pop       = q;
    fif.push_data = d;
    reset         = r;
    #3;
    m_empty      = (q_m.size() == 0);
    m_full       = (q_m.size() == 32);
    exp_pop_ack  = q && !m_empty;
    exp_push_ack = p && !m_full && !exp_pop_ack;
    check("pop_ack",  64'(fif.pop_ack),  64'(exp_pop_ack));
    check("push_ack", 64'(fif.push_ack), 64'(exp_push_ack));
    check("count",    64'(fif.count),    64'(q_m.size()));
    check("full",     64'(fif.full),     64'(m_full));
    check("empty",    64'(fif.empty),    64'(m_empty));
    check("ovf",      64'(fif.ovf),      64'(ovf_m));
    check("udf",      64'(fif.udf),      64'(udf_m));
    check("pop_valid", 64'(fif.pop_valid), 64'(valid_m));
    if (valid_m) check("pop_data", 64'(fif.pop_data), 64'(data_m));
`ifdef RAM_FIFO_HOLD_EN
    else check("pop_data_hold", 64'(fif.pop_data), 64'(hold_m));
`endif
    check("ram_cen", 64'(ram_cen), 64'(exp_pop_ack || exp_push_ack));
    check("ram_wen", 64'(ram_wen), 64'(exp_push_ack));
    check("ram_addr", 64'(ram_addr),
          exp_pop_ack ? 64'(n_pop_m % 32) : (exp_push_ack ? 64'(n_push_m % 32) : 64'd0));
    check("ram_din", 64'(ram_din), exp_push_ack ? 64'(d) : 64'd0);
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (valid_m) hold_m = data_m;
      valid_m = exp_pop_ack;
      if (p && m_full)  ovf_m = 1'b1;
      if (q && m_empty) udf_m = 1'b1;
      if (exp_pop_ack) begin
        data_m = q_m.pop_front();
        n_pop_m++;
      end else if (exp_push_ack) begin
        q_m.push_back(d);
        n_push_m++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fif.push = 1'b0;
    fif.pop = 1'b0;
    fif.push_data = 32'h0;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    model_reset();
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    // Three pushes then three pops
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 32'hA5A5_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    // Fill to 32, then overflow attempt
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 32'(i), 1'b0);
    cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    // Underflow on empty
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    // Pointer wrap: push 20, pop 20, push 20, pop 20
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    // Simultaneous push/pop at count 1, then push retried
    cyc(1'b1, 1'b0, 32'h0000_0AAA, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_0BBB, 1'b0);
    cyc(1'b1, 1'b0, 32'h0000_0BBB, 1'b0);
    // Push and pop while empty-adjacent: pop served first, then push on empty with pop
    cyc(1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_0CCC, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    // Pop accepted in a reset cycle, then idle
    cyc(1'b0, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h1234_5678, 1'b0);
    cyc(1'b0, 1'b1, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      int unsigned mode;
      mode = (i / 250) % 3;
      cyc(($urandom_range(0, 99) < (mode == 0 ? 80 : (mode == 1 ? 30 : 55))),
          ($urandom_range(0, 99) < (mode == 0 ? 25 : (mode == 1 ? 75 : 50))),
          $urandom,
          ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

32-entry FIFO controller that sits directly upstream of the 32x32 single-port RAM and uses it as storage. Converts push/pop requests into RAM cen/wen/addr/din cycles, tracks read/write pointers and occupancy, and returns popped words from the RAM's registered read port. Error flags report overflow and underflow attempts.

## Interface
Parameters:
- DEPTH, 32, entry count; fixed to RAM size (address width 5)
- DW, 32, data width

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- push  in  1  write request
- push_data  in  32  word to write
- pop  in  1  read request
- push_ack  out  1  combinational; push accepted this cycle
- pop_ack  out  1  combinational; pop accepted this cycle
- pop_valid  out  1  registered; pop_data valid this cycle
- pop_data  out  32  popped word
- full  out  1  count == 32
- empty  out  1  count == 0
- count  out  6  occupancy 0..32
- ovf  out  1  sticky: push seen while full
- udf  out  1  sticky: pop seen while empty
- ram_cen  out  1  RAM chip enable
- ram_wen  out  1  RAM write enable
- ram_addr  out  5  RAM address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM registered read data

## Operation
- State: wr_ptr[4:0], rd_ptr[4:0], count[5:0], pop_valid, ovf, udf (plus hold register under config).
- Single RAM port: at most one access per cycle. Priority: pop over push.
- pop_ack = pop & !empty.
- push_ack = push & !full & !pop_ack.
- pop_ack cycle: ram_cen=1, ram_wen=0, ram_addr=rd_ptr, ram_din=0.
- push_ack cycle: ram_cen=1, ram_wen=1, ram_addr=wr_ptr, ram_din=push_data.
- Neither: ram_cen=0, ram_wen=0, ram_addr=0, ram_din=0.
- On push_ack: wr_ptr+1 mod 32, count+1. On pop_ack: rd_ptr+1 mod 32, count-1. Never both in one cycle.
- Pointer wrap 31 -> 0 without gap; full/empty derived from count only, not pointer compare.
- push & full -> no RAM access, ovf set (sticky). pop & empty -> no RAM access, udf set (sticky). Flags clear only on reset.
- push & pop both asserted, non-empty: pop served, push_ack=0, push_data dropped; requester must hold push and retry. push & pop with empty: push served, udf set.
- Requesters may hold push/pop continuously; one transfer per cycle.

## Timing
- Reset (sync): wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, ovf=0, udf=0, hold register=0; empty=1, full=0. RAM contents untouched, treated as garbage.
- reset asserted in a pop_ack cycle: pointer/count update discarded; pop_valid=0 next cycle.
- RAM control outputs combinational from push/pop/state; RAM samples them at the same edge that updates pointers.
- Read latency 1: pop_ack in cycle N -> pop_valid=1 and pop_data=word in cycle N+1.
- Back-to-back pops give pop_valid every cycle, data in FIFO order.
- Write visible to pop the cycle after push_ack (count update at edge).
- full/empty/count reflect registered count; push_ack/pop_ack use current-cycle values.

## Configuration
- RAM_FIFO_HOLD_EN defined: 32-bit hold register captures ram_dout whenever pop_valid=1; pop_data = pop_valid ? ram_dout : hold. Last popped word held until next pop completes.
- Undefined: pop_data = ram_dout directly; value outside pop_valid cycles is whatever the RAM drives (0 on write/idle cycles).

## Test plan
- Reset, then push 0xA5A5_0001..0xA5A5_0003 on 3 cycles -> push_ack=1 each, count=3, ram_wen=1 addr 0,1,2; pop 3 cycles -> pop_valid next cycles with 0xA5A5_0001..3, count=0, empty=1.
- Push 32 words (data=index) -> full=1 at count=32; 33rd push -> push_ack=0, no RAM cycle, ovf=1, count stays 32.
- Pop on empty after reset -> pop_ack=0, ram_cen=0, udf=1, pop_valid=0 next cycle.
- Push 20, pop 20, push 20 (data 0x100+i), pop 20 -> wr_ptr/rd_ptr wrap 31->0, all 0x100..0x113 returned in order.
- count=1, push=1 and pop=1 same cycle -> pop_ack=1, push_ack=0, count=0; next cycle push retried -> accepted, count=1.
- Pop accepted, reset asserted same cycle -> next cycle pop_valid=0, count=0, ovf/udf=0; with RAM_FIFO_HOLD_EN pop_data=0 after reset, and holds last popped value during idle cycles.
